// File: rtl/seq_signed_comparator.sv
// Bit-serial lt/eq/gt compare of two WIDTH-bit operands, signed or unsigned per operation.
// Latency: 1..WIDTH cycles from an accepted start with SEQ_CMP_EARLY_EXIT_EN, otherwise always WIDTH.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted with no idle gap.
module seq_signed_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             is_signed,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx;
   logic             lt_q, eq_q, gt_q;
   logic             accept;
   logic             bit_a, bit_b, differ, last;
   logic             decide, dec_lt, dec_eq, dec_gt;
`ifndef SEQ_CMP_EARLY_EXIT_EN
   logic             seen_q, seen_gt_q;
`endif

   assign accept = start && (state != SCAN);
   assign bit_a  = a_q[idx];
   assign bit_b  = b_q[idx];
   assign differ = bit_a ^ bit_b;
   assign last   = (idx == '0);

   always_comb begin
      state_nxt = state;
      decide    = 1'b0;
      dec_lt    = 1'b0;
      dec_eq    = 1'b0;
      dec_gt    = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = SCAN;
         SCAN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
            if (differ) begin
               decide = 1'b1;
               dec_gt = bit_a;
               dec_lt = ~bit_a;
            end else if (last) begin
               decide = 1'b1;
               dec_eq = 1'b1;
            end
`else
            // Full-length scan: the first difference seen wins, bit 0 only matters if none was seen.
            if (last) begin
               decide = 1'b1;
               if (seen_q) begin
                  dec_gt = seen_gt_q;
                  dec_lt = ~seen_gt_q;
               end else if (differ) begin
                  dec_gt = bit_a;
                  dec_lt = ~bit_a;
               end else begin
                  dec_eq = 1'b1;
               end
            end
`endif
            if (decide) state_nxt = DONE;
         end
         DONE:    state_nxt = start ? SCAN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         idx   <= '0;
         lt_q  <= 1'b0;
         eq_q  <= 1'b0;
         gt_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            // Flipping both MSBs maps two's complement onto offset binary, so the scan stays unsigned.
            a_q  <= is_signed ? (A ^ MSB_MASK) : A;
            b_q  <= is_signed ? (B ^ MSB_MASK) : B;
            idx  <= IW'(WIDTH - 1);
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
         end else if (state == SCAN) begin
            if (decide) begin
               lt_q <= dec_lt;
               eq_q <= dec_eq;
               gt_q <= dec_gt;
            end else begin
               idx <= idx - IW'(1);
            end
         end
      end
   end

`ifndef SEQ_CMP_EARLY_EXIT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seen_q    <= 1'b0;
         seen_gt_q <= 1'b0;
      end else if (accept) begin
         seen_q    <= 1'b0;
         seen_gt_q <= 1'b0;
      end else if (state == SCAN && differ && !seen_q) begin
         seen_q    <= 1'b1;
         seen_gt_q <= bit_a;
      end
   end
`endif

   assign busy = (state == SCAN);
   assign done = (state == DONE);
   assign lt   = lt_q;
   assign eq   = eq_q;
   assign gt   = gt_q;

endmodule

// File: tb/tb_seq_signed_comparator.sv
// Scoreboard bench for seq_signed_comparator: 4-bit and 8-bit instances checked against a reference compare.
module tb_seq_signed_comparator;

   typedef struct {
      logic [2:0] f;    // {lt, eq, gt}
      int         lat;
      int         t0;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start4, start8, sgn4, sgn8;
   logic [3:0] a4, b4;
   logic [7:0] a8, b8;
   logic       busy4, done4, lt4, eq4, gt4;
   logic       busy8, done8, lt8, eq8, gt8;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   exp_t q4[$];
   exp_t q8[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_signed_comparator #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4), .is_signed(sgn4),
      .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gt(gt4));

   seq_signed_comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .is_signed(sgn8),
      .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] ref_flags(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
      longint sa, sb;
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
      if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
      if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
      return {sa < sb, sa == sb, sa > sb};
   endfunction

   function automatic int ref_lat(input int w, input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
      for (int p = w - 1; p >= 0; p--)
         if (a[p] != b[p]) return w - p;
`endif
      return w;
   endfunction

   // Drive a one-cycle start at the current negedge; returns at the negedge after the start edge.
   task automatic start_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic sgn,
                           input bit expect_it);
      exp_t e;
      e.f   = ref_flags(w, {24'b0, a}, {24'b0, b}, sgn);
      e.lat = ref_lat(w, {24'b0, a}, {24'b0, b});
      e.t0  = cyc;
      if (w == 4) begin
         a4 = a[3:0]; b4 = b[3:0]; sgn4 = sgn; start4 = 1'b1;
         if (expect_it) q4.push_back(e);
      end else begin
         a8 = a; b8 = b; sgn8 = sgn; start8 = 1'b1;
         if (expect_it) q8.push_back(e);
      end
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
   endtask

   task automatic wait_done(input int w);
      for (int i = 0; i < 40; i++) begin
         if ((w == 4 && done4) || (w == 8 && done8)) return;
         @(negedge clk);
      end
      chk("done_timeout", 32'd1, 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done4) begin
         if (q4.size() == 0) chk("spurious_done4", 32'd1, 32'd0);
         else begin
            e = q4.pop_front();
            chk("flags4", {29'b0, lt4, eq4, gt4}, {29'b0, e.f});
            chk("lat4", cyc - e.t0 - 1, e.lat);
         end
      end
      if (done8) begin
         if (q8.size() == 0) chk("spurious_done8", 32'd1, 32'd0);
         else begin
            e = q8.pop_front();
            chk("flags8", {29'b0, lt8, eq8, gt8}, {29'b0, e.f});
            chk("lat8", cyc - e.t0 - 1, e.lat);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      exp_t dropped;
      reset = 1'b1;
      start4 = 1'b0; start8 = 1'b0; sgn4 = 1'b0; sgn8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      repeat (3) @(negedge clk);
      chk("rst_outs4", {27'b0, busy4, done4, lt4, eq4, gt4}, 32'd0);
      chk("rst_outs8", {27'b0, busy8, done8, lt8, eq8, gt8}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 1: +1 vs -2 signed -> gt; unsigned -> lt
      start_op(4, 8'h1, 8'hE, 1'b1, 1'b1); wait_done(4); @(negedge clk);
      start_op(4, 8'h1, 8'hE, 1'b0, 1'b1); wait_done(4); @(negedge clk);
      // 2: -2 vs -5
      start_op(4, 8'hE, 8'hB, 1'b1, 1'b1); wait_done(4); @(negedge clk);
      // 3: equal operands, both modes, busy for WIDTH cycles
      for (int m = 0; m < 2; m++) begin
         start_op(4, 8'hF, 8'hF, m[0], 1'b1);
         cnt = 0;
         for (int i = 0; i < 40 && !done4; i++) begin
            if (busy4) cnt++;
            @(negedge clk);
         end
         chk("busy_cycles", cnt, 32'd4);
         @(negedge clk);
      end
      // 4: -4 vs 2, flags hold, then clear on accepted start
      start_op(4, 8'hC, 8'h2, 1'b1, 1'b1); wait_done(4);
      repeat (3) @(negedge clk);
      chk("flags_hold", {29'b0, lt4, eq4, gt4}, 32'b100);
      start_op(4, 8'h6, 8'h7, 1'b1, 1'b1);
      chk("flags_clear", {29'b0, lt4, eq4, gt4}, 32'd0);
      chk("busy_after_start", {31'b0, busy4}, 32'd1);
      wait_done(4); @(negedge clk);
      // 5: start re-pulsed mid-scan is ignored
      start_op(4, 8'h5, 8'h5, 1'b0, 1'b1);
      start_op(4, 8'h0, 8'hF, 1'b0, 1'b0);
      wait_done(4);
      // back-to-back: start during the done cycle is taken with no idle gap
      start_op(4, 8'h8, 8'h7, 1'b1, 1'b1);
      chk("b2b_busy", {31'b0, busy4}, 32'd1);
      wait_done(4); @(negedge clk);
      // 6: reset during scan aborts with no done pulse
      start_op(4, 8'hF, 8'hF, 1'b1, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mid_scan", {27'b0, busy4, done4, lt4, eq4, gt4}, 32'd0);
      dropped = q4.pop_back();
      cnt = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done4) cnt++;
      end
      chk("no_done_after_rst", cnt, 32'd0);
      start_op(4, 8'h3, 8'h9, 1'b1, 1'b1); wait_done(4); @(negedge clk);
      // 8-bit: most-negative vs most-positive, both modes
      start_op(8, 8'h80, 8'h7F, 1'b1, 1'b1); wait_done(8); @(negedge clk);
      start_op(8, 8'h80, 8'h7F, 1'b0, 1'b1); wait_done(8); @(negedge clk);
      // random traffic on both widths
      for (int i = 0; i < 24; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = (i % 5 == 0) ? ra : 8'($urandom_range(0, 255));
         start_op(8, ra, rb, 1'($urandom_range(0, 1)), 1'b1); wait_done(8); @(negedge clk);
         start_op(4, {4'b0, ra[3:0]}, {4'b0, rb[3:0]}, 1'($urandom_range(0, 1)), 1'b1);
         wait_done(4); @(negedge clk);
      end
      repeat (2) @(negedge clk);
      chk("q4_drained", q4.size(), 32'd0);
      chk("q8_drained", q8.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_signed_comparator.md
Name: seq_signed_comparator

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational signed comparator.
- Latches two WIDTH-bit operands on a start pulse and scans them MSB-first, one bit per cycle.
- Reports lt/eq/gt with a one-cycle done pulse.
- Selects signed (two's complement) or unsigned compare per operation; used in the P-series datapath where a small, slow compare is acceptable.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only when not busy.
A  input  WIDTH  operand A; captured on accepted start.
B  input  WIDTH  operand B; captured on accepted start.
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
busy  output  1  high while scanning.
done  output  1  one-cycle pulse when result becomes valid.
lt  output  1  A < B (registered, held).
eq  output  1  A == B (registered, held).
gt  output  1  A > B (registered, held).

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; busy = done = lt = eq = gt = 0.
  - Operand registers and bit index cleared.
  - Reset mid-scan aborts the operation with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE, or DONE, with start = 1 at edge E0:
  - Latch A and B.
  - If is_signed = 1, invert the MSB of both latched copies (offset-binary mapping), so the scan is a pure unsigned compare.
  - idx = WIDTH-1; clear the sticky decision; go to SCAN.
- start while in SCAN is ignored; operands and mode are not re-latched.
- SCAN: busy = 1. At each edge compare a[idx] with b[idx].
  - Bits differ: decision = (a[idx] ? gt : lt).
  - Bits equal and idx > 0: idx decrements.
  - Bits equal and idx == 0: decision = eq.
- On decision:
  - Register lt/eq/gt, one-hot, in the same edge.
  - Go to DONE.
- Latency with early exit: the first differing bit at position p is examined at edge E(WIDTH-p), and done is high in the following cycle.
  - Best case: 1 cycle (MSB differs).
  - Worst case: WIDTH cycles (equal operands).
- DONE: done = 1 for exactly one cycle, busy = 0.
  - Next state is IDLE, or SCAN if start = 1.
- lt/eq/gt hold their last values until the next accepted start.
  - On an accepted start, all three clear to 0 and stay 0 until the decision edge.
- Exactly one of lt/eq/gt is 1 whenever done = 1.
- Boundary cases:
  - Most-negative vs most-positive value resolves at bit WIDTH-1.
  - Signed and unsigned results differ whenever exactly one operand has MSB = 1.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: SCAN terminates on the first differing bit; latency is 1..WIDTH cycles, as above.
- Undefined: SCAN always runs all WIDTH bits, so done always follows edge E(WIDTH).
  - The first differing bit sets a sticky decision; later bits do not change it.
  - Equal is decided only at idx 0 if no difference was seen.
  - Results are identical to the defined build; only timing differs.

Test Plan:
1. WIDTH=4, is_signed=1, A=0001, B=1110 -> gt=1, lt=eq=0; done after E1 with early exit, after E4 without. Same operands with is_signed=0 -> lt=1.
2. WIDTH=4, is_signed=1, A=1110, B=1011 (-2 vs -5) -> gt=1; done after E2 (early exit).
3. WIDTH=4, A=B=1111 in both modes -> eq=1; done after E4; busy high for 4 cycles.
4. WIDTH=4, is_signed=1:
   - A=1100, B=0010 (-4 vs 2) -> lt=1.
   - Then A=0110, B=0111 -> lt=1, done after E4.
   - Between operations: flags hold, then clear on the accepted start.
5. start re-pulsed mid-SCAN with different operands -> ignored; original result reported. Back-to-back start in the DONE cycle -> accepted, with no idle gap.
6. Assert reset during SCAN -> all outputs 0 immediately, no done pulse. After release, a new start operates normally. Also: WIDTH=8, A=8'h80, B=8'h7F -> signed lt=1, unsigned gt=1.
